// File: rtl/clic_int_gate_if.sv
// ---------------------------------------------------------------------------
// clic_int_gate_if
//   Bundles the pad interrupt bus, per-channel trigger configuration, the
//   claim-acknowledge and software-pending-write strobes, and the per-channel
//   status returned to the CLIC arbiter.
//
//   master : drives pads, modes, ack and software writes; observes status
//   slave  : the interrupt gate itself
//
//   Parameters
//     INT_NUM  number of interrupt channels
//     ID_W     width of channel-id fields (2**ID_W >= INT_NUM)
// ---------------------------------------------------------------------------
interface clic_int_gate_if #(
  parameter int INT_NUM = 48,
  parameter int ID_W    = 8
);
  logic [INT_NUM-1:0]   pad_clic_int_vld;
  logic [2*INT_NUM-1:0] int_trig_mode;
  logic                 int_ack_vld;
  logic [ID_W-1:0]      int_ack_id;
  logic                 sw_pend_wr_vld;
  logic [ID_W-1:0]      sw_pend_wr_id;
  logic                 sw_pend_wr_data;
  logic [INT_NUM-1:0]   int_pend;
  logic [INT_NUM-1:0]   int_sync_lvl;
  logic [INT_NUM-1:0]   int_lost;

  modport master (
    output pad_clic_int_vld, int_trig_mode,
    output int_ack_vld, int_ack_id,
    output sw_pend_wr_vld, sw_pend_wr_id, sw_pend_wr_data,
    input  int_pend, int_sync_lvl, int_lost
  );

  modport slave (
    input  pad_clic_int_vld, int_trig_mode,
    input  int_ack_vld, int_ack_id,
    input  sw_pend_wr_vld, sw_pend_wr_id, sw_pend_wr_data,
    output int_pend, int_sync_lvl, int_lost
  );
endinterface

// File: rtl/clic_int_gate.sv
// ---------------------------------------------------------------------------
// clic_int_gate
//   CLIC interrupt-input front end. Synchronises raw pad interrupt lines,
//   applies a per-channel trigger mode (level-high, rising, falling, both
//   edges) and holds per-channel pending bits that are cleared by a claim
//   acknowledge or by a software pending write. A sticky lost flag records
//   an edge that arrived while its channel was still pending.
//
//   Ports
//     forever_cpuclk  clock
//     cpurst_b        synchronous reset, active low
//     bus             clic_int_gate_if.slave:
//                       pad_clic_int_vld  raw request lines
//                       int_trig_mode     [2i+1:2i] 00 level,01 rise,10 fall,11 both
//                       int_ack_*         claim acknowledge pulse + channel id
//                       sw_pend_wr_*      software pending write strobe/id/data
//                       int_pend          pending bits to the arbiter
//                       int_sync_lvl      synchronised input level
//                       int_lost          sticky lost-event flags
//
//   Parameters
//     INT_NUM      channel count (1..240)
//     SYNC_STAGES  synchroniser depth (0 = inputs already synchronous, 1..3)
//     ID_W         channel-id width
// ---------------------------------------------------------------------------
module clic_int_gate #(
  parameter int INT_NUM     = 48,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = 8
) (
  input  logic            forever_cpuclk,
  input  logic            cpurst_b,
  clic_int_gate_if.slave  bus
);

  typedef enum logic [1:0] {
    TRIG_LEVEL = 2'b00,
    TRIG_RISE  = 2'b01,
    TRIG_FALL  = 2'b10,
    TRIG_BOTH  = 2'b11
  } trig_e;

  logic [INT_NUM-1:0] s;        // synchronised level
  logic [INT_NUM-1:0] hist_q;   // s delayed by one cycle, for edge detection
  logic [INT_NUM-1:0] pend_q, pend_d;
  logic [INT_NUM-1:0] lost_q, lost_d;
  logic [ID_W-1:0]    ack_id;
  logic [ID_W-1:0]    sw_id;

  assign ack_id = bus.int_ack_id;
  assign sw_id  = bus.sw_pend_wr_id;

  // -------------------------------------------------------------------------
  // Synchroniser
  // -------------------------------------------------------------------------
  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = bus.pad_clic_int_vld;
  end else begin : g_sync
    logic [INT_NUM-1:0] sync_q [SYNC_STAGES];

    // NOTE: the stage array is reset explicitly, element by element; a flop
    // array is not cleared just because it sits in a clocked block, and a
    // stale 1 here would look like a real edge right after reset.
    always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
        for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
        sync_q[0] <= bus.pad_clic_int_vld;
        for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  // -------------------------------------------------------------------------
  // Per-channel next state
  // -------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the loop, so no
  // path leaves a bit unassigned and no latch is inferred.
  always_comb begin
    pend_d = pend_q;
    lost_d = lost_q;
    for (int i = 0; i < INT_NUM; i++) begin
      trig_e mode;
      logic  rise, fall, ev, sw_hit, ack_hit, lost_set, lost_clr;
      mode    = trig_e'(bus.int_trig_mode[2*i +: 2]);
      rise    = s[i] & ~hist_q[i];
      fall    = ~s[i] & hist_q[i];
      // Ids at or above INT_NUM never equal any loop index, so they are ignored.
      sw_hit  = bus.sw_pend_wr_vld && (int'(sw_id) == i);
      ack_hit = bus.int_ack_vld && (int'(ack_id) == i);
      case (mode)
        TRIG_RISE: ev = rise;
        TRIG_FALL: ev = fall;
        TRIG_BOTH: ev = rise | fall;
        default:   ev = 1'b0;
      endcase

      if (mode == TRIG_LEVEL) begin
        pend_d[i] = s[i];
        lost_d[i] = 1'b0;
      end else begin
        // A new event outranks both clears; software write outranks ack.
        if (ev)           pend_d[i] = 1'b1;
        else if (sw_hit)  pend_d[i] = bus.sw_pend_wr_data;
        else if (ack_hit) pend_d[i] = 1'b0;
        else              pend_d[i] = pend_q[i];

        // An edge landing on a pending channel is only "lost" when nothing in
        // the same cycle is consuming the old pending state.
        lost_set = ev && pend_q[i] && !ack_hit && !(sw_hit && !bus.sw_pend_wr_data);
        // An ack that coincides with a fresh edge on a pending channel keeps
        // the flag: that edge is merged into the pending bit.
        lost_clr = ack_hit && !(ev && pend_q[i]);
        if (lost_set)      lost_d[i] = 1'b1;
        else if (lost_clr) lost_d[i] = 1'b0;
      end
    end
  end

  // NOTE: state flops use non-blocking assignment so every channel samples
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      hist_q <= '0;
      pend_q <= '0;
      lost_q <= '0;
    end else begin
      hist_q <= s;
      pend_q <= pend_d;
      lost_q <= lost_d;
    end
  end

  assign bus.int_pend     = pend_q;
  assign bus.int_lost     = lost_q;
  assign bus.int_sync_lvl = s;

endmodule
